// File: rtl/mips_register_file.sv
// MIPS 32 x 32 register file: two async read ports, one sync write port, $0 hardwired.
// Optional write-through forwarding when WRITE_BYPASS_EN is defined.
module mips_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [Depth];
   logic                  writeEn;

   assign writeEn = RegWrite && !reset && (write_reg != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < Depth; i++) begin
            regs[i] <= '0;
         end
      end else if (writeEn) begin
         regs[write_reg] <= write_data;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] readPort(
      input logic [ADDR_WIDTH-1:0] idx
   );
      logic [DATA_WIDTH-1:0] val;
      val = (idx == '0) ? '0 : regs[idx];
`ifdef WRITE_BYPASS_EN
      // writeEn already excludes $0 and reset, so no extra guard needed
      if (writeEn && (idx == write_reg)) begin
         val = write_data;
      end
`endif
      return val;
   endfunction

   assign read_data1 = readPort(read_reg1);
   assign read_data2 = readPort(read_reg2);

endmodule
